// File: rtl/rle_pkg.sv
// rle_pkg: shared default widths, run-limit helper and state encoding for the run-length encoder
package rle_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF = 3;
  localparam int TIMEOUT_DEF = 0;
  typedef logic [1:0] state_t;
  // bit 1 = output slot full, bit 0 = run open
  localparam state_t EMPTY = 2'b00;
  localparam state_t RUN = 2'b01;
  localparam state_t OUT = 2'b10;
  localparam state_t RUN_OUT = 2'b11;
  function automatic int max_run(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction
endpackage

// File: rtl/rle_encoder_if.sv
// rle_encoder_if: symbol input handshake, flush and (symbol, count) output handshake
// master: source/sink side (drives in_valid, in, flush, out_ready)
// slave: encoder side (drives in_ready, data, count, valid)
interface rle_encoder_if import rle_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic in_valid;
  logic [DATA_W-1:0] in;
  logic in_ready;
  logic flush;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0] count;
  logic valid;
  logic out_ready;
  modport master(output in_valid, in, flush, out_ready, input in_ready, data, count, valid);
  modport slave(input in_valid, in, flush, out_ready, output in_ready, data, count, valid);
endinterface

// File: rtl/rle_out_slot.sv
// rle_out_slot: registered valid/ready output stage holding one (symbol, count) pair
// ports: clk, rst (async high); load/ld_data/ld_count fill the slot; out_ready drains it;
// data/count/valid are the registered outputs; slot_free says a load may happen this cycle
module rle_out_slot import rle_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CNT_W-1:0]  ld_count,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              valid,
  output logic              slot_free
);
  assign slot_free = !valid || out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      if (load) begin
        data <= ld_data;
        count <= ld_count;
      end
      valid <= load || (valid && !out_ready);
    end
endmodule

// File: rtl/rle_encoder.sv
// rle_encoder: run-length encoder emitting (symbol, run length) pairs with split, flush and idle timeout
// ports: clk, rst (async high); bus (rle_encoder_if.slave): in_valid/in/in_ready symbol input,
// flush level request, data/count/valid/out_ready registered run output
module rle_encoder import rle_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  rle_encoder_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(max_run(CNT_W));
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic act, act_d;
  logic [DATA_W-1:0] sym, sym_d, data_q;
  logic [CNT_W-1:0] cnt, cnt_d, count_q;
  logic [TW-1:0] tmr, tmr_d;
  logic vld, slot_free, rdy, acc, sat, tmo, extend, load, run_on;
  state_t state;
  assign state = {vld, act};
  assign run_on = state == RUN || state == RUN_OUT;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      act <= 1'b0;
      sym <= '0;
      cnt <= '0;
      tmr <= '0;
    end else begin
      act <= act_d;
      sym <= sym_d;
      cnt <= cnt_d;
      tmr <= tmr_d;
    end
  // an accept in the same cycle as a timeout wins: the run is no longer idle
  always_comb begin
    act_d = acc || (run_on && !load);
    sym_d = acc ? bus.in : sym;
    cnt_d = acc ? (extend ? cnt + CNT_W'(1) : CNT_W'(1)) : (load ? '0 : cnt);
    tmr_d = (acc || load || !run_on) ? '0 : (sat ? tmr : tmr + TW'(1));
  end
  always_comb begin
    rdy = slot_free && !bus.flush;
    acc = bus.in_valid && rdy;
    sat = tmr == TW'(TIMEOUT);
    tmo = TIMEOUT > 0 && sat;
    extend = run_on && bus.in == sym && cnt != MAX;
    load = run_on && (acc ? !extend : (bus.flush || tmo) && slot_free);
  end
  rle_out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot (
    .clk(clk),
    .rst(rst),
    .load(load),
    .ld_data(sym),
    .ld_count(cnt),
    .out_ready(bus.out_ready),
    .data(data_q),
    .count(count_q),
    .valid(vld),
    .slot_free(slot_free)
  );
  assign bus.in_ready = rdy;
  assign bus.data = data_q;
  assign bus.count = count_q;
  assign bus.valid = vld;
endmodule
